// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame states, parity
// selectors and the supported data-width range.
package uart_pkg;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } tx_state_e;

  // Plain-vector aliases so the state register stays a legacy logic vector.
  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_START  = S_START;
  localparam logic [2:0] ST_DATA   = S_DATA;
  localparam logic [2:0] ST_PARITY = S_PARITY;
  localparam logic [2:0] ST_STOP1  = S_STOP1;
  localparam logic [2:0] ST_STOP2  = S_STOP2;

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the latched transmit word and the bit counter, and presents the data
// bit addressed by the counter (mirrored for MSB-first frames).
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  bit_sel,
  output logic                  last
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      data  <= p_data;
      cnt_q <= '0;
    end else if (shift && !last) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign last    = (cnt_q == LAST_IDX);
  assign idx     = (MSB_FIRST != 0) ? (LAST_IDX - cnt_q) : cnt_q;
  assign bit_sel = data[idx];

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, data, optional parity, one or two stop
// bits, one bit per CLK, with gapless back-to-back frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_READY,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
    $error("uart_tx_frame: DATA_WIDTH %0d outside %0d..%0d",
           DATA_WIDTH, DATA_WIDTH_MIN, DATA_WIDTH_MAX);
  end

  // Handshake: a word is taken on a rising edge where DATA_VALID and TX_READY
  // are both 1; upstream must hold P_DATA and config stable until then.
  logic [2:0]            state_q, state_d;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic                  final_stop, accept;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_bit, data_last, par_bit, bit_sel;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_ser (
    .CLK     (CLK),
    .RST     (RST),
    .load    (accept),
    .shift   (state_q == ST_DATA),
    .p_data  (P_DATA),
    .data    (data),
    .bit_sel (data_bit),
    .last    (data_last)
  );

  assign final_stop = stop2_q ? (state_q == ST_STOP2) : (state_q == ST_STOP1);
  assign TX_READY   = (state_q == ST_IDLE) || final_stop;
  assign accept     = DATA_VALID && TX_READY;
  assign par_bit    = (par_typ_q == PAR_ODD) ? ~(^data) : (^data);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   if (data_last) state_d = par_en_q ? ST_PARITY : ST_STOP1;
      ST_PARITY: state_d = ST_STOP1;
      ST_STOP1:  state_d = stop2_q ? ST_STOP2 : (accept ? ST_START : ST_IDLE);
      ST_STOP2:  state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_sel = 1'b1;
    case (state_q)
      ST_START:  bit_sel = 1'b0;
      ST_DATA:   bit_sel = data_bit;
      ST_PARITY: bit_sel = par_bit;
      default:   bit_sel = 1'b1;
    endcase
  end

  // TX_OUT and BUSY trail the state by one cycle, so both reflect the bit
  // chosen by the state that was current at the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      TX_OUT  <= bit_sel;
      BUSY    <= (state_q != ST_IDLE);
      if (accept) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an LSB-first and an MSB-first instance share
// stimulus; a line-level model predicts every cycle of both serial outputs.
module tb_uart_tx_frame;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic          rdy_l, tx_l, busy_l;
  logic          rdy_m, tx_m, busy_m;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(DW), .MSB_FIRST(0)) u_lsb (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_READY(rdy_l), .TX_OUT(tx_l), .BUSY(busy_l)
  );

  uart_tx_frame #(.DATA_WIDTH(DW), .MSB_FIRST(1)) u_msb (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_READY(rdy_m), .TX_OUT(tx_m), .BUSY(busy_m)
  );

  // Bits accepted but not yet shown on the line, per instance.
  bit         line_l[$];
  bit         line_m[$];
  // Per-cycle expectation {ready, busy, tx} consumed by the monitor.
  logic [2:0] exp_l[$];
  logic [2:0] exp_m[$];
  logic [2:0] mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  bit         last_accept = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    bit p;
    line_l.push_back(1'b0);
    line_m.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      line_l.push_back(P_DATA[i]);
      line_m.push_back(P_DATA[DW-1-i]);
    end
    if (PAR_EN) begin
      p = bit'($countones(P_DATA) % 2) ^ PAR_TYP;
      line_l.push_back(p);
      line_m.push_back(p);
    end
    line_l.push_back(1'b1);
    line_m.push_back(1'b1);
    if (STOP2) begin
      line_l.push_back(1'b1);
      line_m.push_back(1'b1);
    end
  endtask

  // One clock of the reference model; inputs may be changed after it returns.
  task automatic tick();
    bit tx_el, tx_em, busy_e, rdy_e, acc;
    @(posedge CLK);
    acc = 1'b0;
    tx_el = 1'b1;
    tx_em = 1'b1;
    busy_e = 1'b0;
    if (!RST) begin
      line_l.delete();
      line_m.delete();
    end else begin
      acc = DATA_VALID && (line_l.size() <= 1);
      if (line_l.size() > 0) begin
        tx_el  = line_l.pop_front();
        tx_em  = line_m.pop_front();
        busy_e = 1'b1;
      end
      if (acc) push_frame();
    end
    rdy_e = !RST || (line_l.size() <= 1);
    exp_l.push_back({rdy_e, busy_e, tx_el});
    exp_m.push_back({rdy_e, busy_e, tx_em});
    last_accept = acc;
    #1;
  endtask

  task automatic idle(input int n);
    DATA_VALID = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input logic s2);
    bit ok;
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    STOP2 = s2;
    DATA_VALID = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      ok = last_accept;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_timeout: word %h not taken within 40 cycles", d);
    end
  endtask

  task automatic check_reset_now();
    check("rst_tx_lsb", tx_l, 1'b1);
    check("rst_busy_lsb", busy_l, 1'b0);
    check("rst_ready_lsb", rdy_l, 1'b1);
    check("rst_tx_msb", tx_m, 1'b1);
    check("rst_busy_msb", busy_m, 1'b0);
    check("rst_ready_msb", rdy_m, 1'b1);
  endtask

  always @(negedge CLK) begin
    if (exp_l.size() > 0) begin
      mon_e = exp_l.pop_front();
      check("tx_lsb", tx_l, mon_e[0]);
      check("busy_lsb", busy_l, mon_e[1]);
      check("ready_lsb", rdy_l, mon_e[2]);
    end
    if (exp_m.size() > 0) begin
      mon_e = exp_m.pop_front();
      check("tx_msb", tx_m, mon_e[0]);
      check("busy_msb", busy_m, mon_e[1]);
      check("ready_msb", rdy_m, mon_e[2]);
    end
  end

  initial begin
    #1 RST = 1'b0;
    #1 check_reset_now();
    repeat (3) tick();
    RST = 1'b1;
    idle(20);

    send(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(14);
    send(8'h07, 1'b1, 1'b1, 1'b1);
    idle(14);

    // Back-to-back words with DATA_VALID held high.
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0, 1'b0);
    idle(14);

    // Config and data change while a frame is in flight.
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    DATA_VALID = 1'b0;
    repeat (3) tick();
    P_DATA = 8'hC3;
    PAR_EN = 1'b0;
    STOP2 = 1'b0;
    PAR_TYP = 1'b1;
    repeat (3) tick();
    send(8'hC3, 1'b0, 1'b1, 1'b0);
    idle(14);

    // Reset asserted while data bits are on the line.
    send(8'h5A, 1'b1, 1'b1, 1'b0);
    idle(4);
    @(negedge CLK);
    #1 RST = 1'b0;
    #1 check_reset_now();
    repeat (3) tick();
    RST = 1'b1;
    idle(2);
    send(8'h96, 1'b1, 1'b0, 1'b1);
    idle(14);

    repeat (40) begin
      send(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(16);
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
